// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: RV32 base opcodes, immediate-format encodings and the
// registered beat payload carried by the IF/ID stage.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate formats as understood by imm_gen.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef struct packed {
    logic [24:0] inst;
    logic [6:0]  opcode;
    imm_sel_e    imm_sel;
    logic        has_imm;
    logic        illegal;
  } dec_beat_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the IF/ID stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [24:0]     out_inst;
  logic [2:0]      out_imm_sel;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_has_imm;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_imm_sel, out_opcode,
           out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_has_imm, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_imm_sel, out_opcode,
           out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_has_imm, out_illegal
  );
endinterface

// File: rtl/decode_stage_inst_decode.sv
// Combinational opcode classifier: immediate format, immediate usage and illegal flag.
// Unknown opcodes (including inst[1:0] != 2'b11) report illegal with format I and no immediate.
module inst_decode
  import decode_stage_pkg::*;
(
  input  logic [31:0] inst,
  output imm_sel_e    imm_sel,
  output logic        has_imm,
  output logic        illegal
);

  always_comb begin
    imm_sel = IMM_I;
    has_imm = 1'b1;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_SYSTEM, OPC_FENCE: imm_sel = IMM_I;
      OPC_STORE:             imm_sel = IMM_S;
      OPC_BRANCH:            imm_sel = IMM_B;
      OPC_LUI, OPC_AUIPC:    imm_sel = IMM_U;
      OPC_JAL:               imm_sel = IMM_J;
      OPC_OP:                has_imm = 1'b0;
      default: begin
        has_imm = 1'b0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID stage: registers fetched beats with their decode in a main + skid buffer so
// in_ready comes straight from a flop; strict FIFO order, flush drops everything held.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  decode_stage_if.slave bus
);

  imm_sel_e  dec_imm_sel;
  logic      dec_has_imm;
  logic      dec_illegal;
  dec_beat_t in_beat;

  inst_decode u_inst_decode (
    .inst    (bus.in_inst[31:0]),
    .imm_sel (dec_imm_sel),
    .has_imm (dec_has_imm),
    .illegal (dec_illegal)
  );

  always_comb begin
    in_beat.inst    = bus.in_inst[31:7];
    in_beat.opcode  = bus.in_inst[6:0];
    in_beat.imm_sel = dec_imm_sel;
    in_beat.has_imm = dec_has_imm;
    in_beat.illegal = dec_illegal;
  end

  logic            main_vld_q, main_vld_d;
  logic            skid_vld_q, skid_vld_d;
  dec_beat_t       main_q, main_d;
  dec_beat_t       skid_q, skid_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;

  logic accept;
  logic xfer;

  // Without the skid entry, ready must look through to out_ready to keep full throughput.
  assign bus.in_ready = SKID_EN ? ~skid_vld_q : (~main_vld_q | bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign xfer         = main_vld_q & bus.out_ready;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    main_pc_d  = main_pc_q;
    skid_pc_d  = skid_pc_q;
    if (bus.flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (xfer || !main_vld_q) begin
      // in_ready is low whenever skid holds a beat, so refill-from-skid never races an accept.
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_d     = skid_q;
        main_pc_d  = skid_pc_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_vld_d = 1'b1;
        main_d     = in_beat;
        main_pc_d  = bus.in_pc;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept && SKID_EN) begin
      skid_vld_d = 1'b1;
      skid_d     = in_beat;
      skid_pc_d  = bus.in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
      main_pc_q  <= '0;
      skid_pc_q  <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_pc_q  <= main_pc_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  assign bus.out_valid   = main_vld_q;
  assign bus.out_pc      = main_pc_q;
  assign bus.out_inst    = main_q.inst;
  assign bus.out_imm_sel = main_q.imm_sel;
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_has_imm = main_q.has_imm;
  assign bus.out_illegal = main_q.illegal;
  // Field slices of inst[31:7], offset by 7.
  assign bus.out_rd      = main_q.inst[4:0];
  assign bus.out_funct3  = main_q.inst[7:5];
  assign bus.out_rs1     = main_q.inst[12:8];
  assign bus.out_rs2     = main_q.inst[17:13];
  assign bus.out_funct7  = main_q.inst[24:18];

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-computed decode fields, handshake ordering,
// flush and asynchronous reset, with a small imm_gen model to check immediates.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference imm_gen fed from out_inst/out_imm_sel.
  function automatic logic [31:0] imm_of(input logic [24:0] hi, input logic [2:0] sel);
    logic [31:0] i;
    i = {hi, 7'b0};
    case (sel)
      3'd1:    imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    imm_of = {i[31:12], 12'b0};
      3'd4:    imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_of = {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = vld;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
  endtask

  initial begin
    n_chk          = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_inst    = '0;
    bus.in_pc      = '0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    step();
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_inst", {7'b0, bus.out_inst}, 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    #3 rst_n = 1'b1;
    step();

    // addi x8, x9, 12
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h00C48413, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("addi_inst", {7'b0, bus.out_inst}, 32'h18908);
    chk("addi_sel", {29'b0, bus.out_imm_sel}, 32'(IMM_I));
    chk("addi_rd", {27'b0, bus.out_rd}, 32'd8);
    chk("addi_rs1", {27'b0, bus.out_rs1}, 32'd9);
    chk("addi_has_imm", {31'b0, bus.out_has_imm}, 32'd1);
    chk("addi_illegal", {31'b0, bus.out_illegal}, 32'd0);
    chk("addi_pc", bus.out_pc, 32'h100);
    chk("addi_imm", imm_of(bus.out_inst, bus.out_imm_sel), 32'd12);
    step();
    chk("addi_drained", {31'b0, bus.out_valid}, 32'd0);

    // beq then lui back-to-back
    drive(1'b1, 32'hFEA48863, 32'h104);
    step();
    chk("beq_sel", {29'b0, bus.out_imm_sel}, 32'(IMM_B));
    chk("beq_rs1", {27'b0, bus.out_rs1}, 32'd9);
    chk("beq_rs2", {27'b0, bus.out_rs2}, 32'd10);
    chk("beq_imm", imm_of(bus.out_inst, bus.out_imm_sel), 32'hFFFFF7F0);
    drive(1'b1, 32'h54321437, 32'h108);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("lui_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("lui_pc", bus.out_pc, 32'h108);
    chk("lui_sel", {29'b0, bus.out_imm_sel}, 32'(IMM_U));
    chk("lui_rd", {27'b0, bus.out_rd}, 32'd8);
    chk("lui_imm", imm_of(bus.out_inst, bus.out_imm_sel), 32'h54321000);
    step();

    // Backpressure: sh, jal, addi with out_ready low
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00941823, 32'h200);
    step();
    chk("bp_ready_1", {31'b0, bus.in_ready}, 32'd1);
    drive(1'b1, 32'h7FFFF0EF, 32'h204);
    step();
    chk("bp_ready_2", {31'b0, bus.in_ready}, 32'd0);
    drive(1'b1, 32'hFFC48413, 32'h208);
    step();
    chk("bp_ready_held", {31'b0, bus.in_ready}, 32'd0);
    chk("bp_hold_pc", bus.out_pc, 32'h200);
    chk("bp_hold_sel", {29'b0, bus.out_imm_sel}, 32'(IMM_S));
    chk("bp_sh_imm", imm_of(bus.out_inst, bus.out_imm_sel), 32'd16);
    bus.out_ready = 1'b1;
    step();
    chk("bp_jal_pc", bus.out_pc, 32'h204);
    chk("bp_jal_sel", {29'b0, bus.out_imm_sel}, 32'(IMM_J));
    chk("bp_jal_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("bp_addi_pc", bus.out_pc, 32'h208);
    chk("bp_addi_sel", {29'b0, bus.out_imm_sel}, 32'(IMM_I));
    chk("bp_addi_imm", imm_of(bus.out_inst, bus.out_imm_sel), 32'hFFFFFFFC);
    step();
    chk("bp_drained", {31'b0, bus.out_valid}, 32'd0);

    // Flush with main and skid full and a beat offered
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00C48413, 32'h300);
    step();
    drive(1'b1, 32'h00941823, 32'h304);
    step();
    drive(1'b1, 32'h54321437, 32'h308);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("fl_ready", {31'b0, bus.in_ready}, 32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("fl_no_ghost", {31'b0, bus.out_valid}, 32'd0);
    // Flush drops a beat accepted the same cycle into an empty stage
    drive(1'b1, 32'h00C48413, 32'h30C);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_same_cycle", {31'b0, bus.out_valid}, 32'd0);

    // Illegal encodings and register-register add
    drive(1'b1, 32'h0000007F, 32'h400);
    step();
    chk("ill7f_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("ill7f_illegal", {31'b0, bus.out_illegal}, 32'd1);
    chk("ill7f_has_imm", {31'b0, bus.out_has_imm}, 32'd0);
    chk("ill7f_sel", {29'b0, bus.out_imm_sel}, 32'(IMM_I));
    drive(1'b1, 32'h00000001, 32'h404);
    step();
    chk("ill01_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("ill01_illegal", {31'b0, bus.out_illegal}, 32'd1);
    chk("ill01_has_imm", {31'b0, bus.out_has_imm}, 32'd0);
    drive(1'b1, 32'h00A48433, 32'h408);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("add_illegal", {31'b0, bus.out_illegal}, 32'd0);
    chk("add_has_imm", {31'b0, bus.out_has_imm}, 32'd0);
    chk("add_rs2", {27'b0, bus.out_rs2}, 32'd10);
    chk("add_opcode", {25'b0, bus.out_opcode}, 32'h33);
    step();

    // Asynchronous reset mid-cycle with both entries full
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFEA48863, 32'h500);
    step();
    drive(1'b1, 32'h54321437, 32'h504);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_full", {31'b0, bus.in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("ar_inst", {7'b0, bus.out_inst}, 32'd0);
    chk("ar_ready", {31'b0, bus.in_ready}, 32'd1);
    #1 rst_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h00C48413, 32'h600);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("ar_new_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("ar_new_pc", bus.out_pc, 32'h600);
    chk("ar_new_imm", imm_of(bus.out_inst, bus.out_imm_sel), 32'd12);
    step();
    chk("ar_new_drained", {31'b0, bus.out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- IF/ID pipeline stage between instruction fetch and the execute datapath.
- Registers each fetched instruction and decodes opcode into imm_sel (I/S/B/U/J), register fields and illegal flag.
- Presents inst[31:7] plus imm_sel to imm_gen and the register file.
- Valid/ready handshake on both sides; 2-entry (main + skid) buffer so in_ready is a registered signal; flush support for branch redirect.

Parameters:
- XLEN, 32, width of PC and instruction word.
- SKID_EN, 1, 1 = skid entry present (in_ready registered); 0 = single entry, in_ready = ~out_valid | out_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch beat valid.
- in_ready  out  1  stage can accept a beat.
- in_inst  in  XLEN  fetched instruction.
- in_pc  in  XLEN  PC of in_inst.
- flush  in  1  discard all held and incoming beats.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  downstream accepts beat.
- out_pc  out  XLEN  PC of decoded beat.
- out_inst  out  25  instruction bits [31:7], feeds imm_gen inst.
- out_imm_sel  out  3  immediate format, feeds imm_gen imm_sel.
- out_opcode  out  7  inst[6:0].
- out_rd / out_rs1 / out_rs2  out  5 each  inst[11:7] / [19:15] / [24:20].
- out_funct3  out  3  inst[14:12].
- out_funct7  out  7  inst[31:25].
- out_has_imm  out  1  instruction uses an immediate.
- out_illegal  out  1  unrecognised opcode or inst[1:0] != 2'b11.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid valid=0, all out_* data=0, in_ready=1. Any beat in flight is lost.
- Decode is combinational on in_inst; results are registered with the beat. Latency: accepted at edge N, out_valid=1 after edge N.
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- Main register is loaded on accept when main is empty or transferring that cycle; otherwise the beat goes to skid.
- Skid is loaded when main is full and not transferring. On main transfer with skid valid, skid moves to main and skid clears.
- Accept with skid full is impossible because in_ready=0.
- in_ready = ~skid_valid, registered. Order is strictly FIFO. Data is held stable while out_valid & ~out_ready.
- Simultaneous transfer and accept with skid empty: the new beat goes directly to main; out_valid stays 1.
- flush=1: at the next edge main and skid valid clear. A beat accepted in the same cycle is dropped. in_ready=1 the following cycle. Flush has priority over accept and transfer; downstream still sees the transfer handshake that cycle.
- imm_sel map (encodings from the shared imm_sel.vh macros):
  - I_TYPE: 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR, 1110011 SYSTEM, 0001111 FENCE.
  - S_TYPE: 0100011.
  - B_TYPE: 1100011.
  - U_TYPE: 0110111 LUI, 0010111 AUIPC.
  - J_TYPE: 1101111.
  - 0110011 OP: imm_sel=I_TYPE (don't-care), has_imm=0.
- has_imm=1 for every legal opcode except OP.
- Illegal beats: illegal=1, has_imm=0, imm_sel=I_TYPE. They propagate normally and are never dropped.
- Field outputs are raw bit slices, independent of format.

Decomposition:
- Shared package/header: opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM). imm_sel encodings stay in imm_sel.vh.
- Sub-module inst_decode: purely combinational, in_inst -> {imm_sel, has_imm, illegal}. Reused by the later full control unit.
- decode_stage owns the handshake, skid buffer and registers.

Test Plan:
- addi 0x00C48413, pc 0x100, out_ready=1 -> next cycle out_valid=1, out_inst=0x18908, imm_sel=I_TYPE, rd=8, rs1=9, has_imm=1, illegal=0. imm_gen driven from the outputs yields 12.
- beq 0xFEA48863 then lui 0x54321437 back-to-back -> B_TYPE with rs1=9, rs2=10, followed by U_TYPE with rd=8. imm_gen gives -2064 then 0x54321000; no bubble.
- Backpressure: out_ready=0, send sh 0x00941823, jal 0x7FFFF0EF, addi 0xFFC48413:
  - in_ready=0 after the second accept; the third beat is held upstream.
  - Raise out_ready: outputs arrive in order S_TYPE, J_TYPE, I_TYPE, one per cycle, with no loss or duplication.
- Flush with main and skid full plus in_valid=1 -> next cycle out_valid=0 and in_ready=1; none of the three beats ever appears.
- 0x0000007F and 0x00000001 -> out_illegal=1, has_imm=0, out_valid=1 each. add 0x00A48433 -> has_imm=0, illegal=0.
- Assert rst_n=0 asynchronously mid-cycle while both entries are full -> out_valid=0 and out_inst=0 immediately. After release, in_ready=1 and the first new beat decodes correctly.
